uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive buffer between the `uart` core's receive handshake (`rx_data`/`rx_avail`/`rx_error`/`rx_ack`) and the UART bus peripheral. It acknowledges every received byte on its own and stores it in a show-ahead FIFO. Software no longer has to service each byte within one character time. It also reports overflow and, optionally, per-byte framing errors.

## Interface
- `DEPTH`, 16: number of FIFO entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width (derived, not overridden).
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte from the `uart` core.
- `rx_avail` in 1: core holds a byte; level, drops after `rx_ack` is seen.
- `rx_error` in 1: framing error on the current byte, valid with `rx_avail`.
- `rx_ack` out 1: acknowledge to the core; registered level.
- `rd_en` in 1: pop the head entry; ignored when `empty`.
- `rd_data` out 8: head byte, show-ahead; valid while `!empty`.
- `rd_err` out 1: error flag of the head entry; constant 0 without `UART_RX_FIFO_ERR_EN`.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out AW+1: number of stored entries.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `clr_ovf` in 1: clears `overflow`.

## Operation
- Storage: `DEPTH` × 9-bit memory ({err, data}). Write and read pointers are AW+1 bits; the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `count` = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Capture FSM, two states:
  - `IDLE`: if `rx_avail`=1 at the clock edge, push the byte (see push rule), set `rx_ack`←1, go to `ACK`.
  - `ACK`: hold `rx_ack`=1. When `rx_avail`=0 is sampled, set `rx_ack`←0 and go to `IDLE`.
  - Each byte is captured exactly once (4-phase handshake). A new `rx_avail` is not sampled until the FSM is back in `IDLE`.
- Push rule:
  - The byte is written if `!full`, or if `full` and `rd_en`=1 in the same cycle (simultaneous pop frees the slot).
  - Otherwise the byte is dropped, `overflow`←1, and `rx_ack` is still asserted so the core never stalls.
- Pop: `rd_en`=1 with `!empty` advances rd_ptr. `rd_en` on empty has no effect.
- Simultaneous push and pop: both pointers advance and `count` is unchanged. On an empty FIFO only the push takes effect; the pop is ignored.
- Pointer wrap: the low AW bits roll over at `DEPTH`; the wrap bit toggles.
- `overflow`: a set and `clr_ovf` in the same cycle leaves it set (set wins).
- Reset (asynchronous, mid-operation allowed): pointers 0, state `IDLE`, `rx_ack`=0, `overflow`=0. Memory contents are not reset.
  - Resulting outputs: `empty`=1, `full`=0, `count`=0, `rd_data`/`rd_err` undefined but masked by `empty`.
  - A byte pending in the core at reset release is captured normally.

## Timing
- `rx_avail` rising sampled at edge N: `rx_ack`=1, `empty`=0 and `count`+1 are visible after edge N. `rd_data` shows the byte in the same cycle if the FIFO was empty.
- `rx_ack` falls one edge after `rx_avail`=0 is sampled.
- Minimum capture period: 3 cycles per byte (avail → ack → release).
- Pop: `rd_data` and `rd_err` update to the next entry after the edge at which `rd_en`=1. `count`, `empty` and `full` update at the same edge.
- `overflow` rises at the edge at which the byte is dropped.

## Configuration
- `UART_RX_FIFO_ERR_EN` defined: `rx_error` is stored with each byte and presented on `rd_err` alongside `rd_data`.
- Not defined:
  - Bytes received with `rx_error`=1 are acknowledged and discarded. They are not written and do not set `overflow`.
  - Memory is 8 bits wide and `rd_err` is tied to 0.

## Test plan
- Reset, then 3 bytes 0x41, 0x42, 0x43 via the core handshake -> `rx_ack` one pulse per byte, `count`=3, pops return 0x41, 0x42, 0x43, then `empty`=1.
- Write 17 bytes with DEPTH=16 and no pops -> `full`=1 after byte 16, byte 17 acked and dropped, `overflow`=1, first pop returns byte 1. `clr_ovf` -> `overflow`=0.
- Full FIFO with `rd_en`=1 in the same cycle the 17th byte is captured -> byte stored, `overflow`=0, `count` stays 16.
- 40 push/pop pairs with `count` oscillating between 0 and 2 -> data in order across pointer wrap; `full` never asserted.
- Byte 0x55 with `rx_error`=1 -> with the macro: `rd_data`=0x55, `rd_err`=1. Without the macro: acked, `empty` stays 1.
- Assert `rst`=0 while in `ACK` with `count`=5 -> immediately `rx_ack`=0, `count`=0, `empty`=1. After release, the next `rx_avail` is captured normally.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bundled signals between the uart core receive handshake, the receive FIFO and its reader.
// The FIFO uses the slave modport; the core/reader side uses master.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_error;
    logic        rx_ack;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overflow;
    logic        clr_ovf;

    modport master (
        output rx_data, rx_avail, rx_error, rd_en, clr_ovf,
        input  rx_ack, rd_data, rd_err, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, rx_avail, rx_error, rd_en, clr_ovf,
        output rx_ack, rd_data, rd_err, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Self-acknowledging receive buffer: captures each byte from the uart core into a show-ahead FIFO.
// Define UART_RX_FIFO_ERR_EN to store the framing-error flag per byte; otherwise errored bytes are discarded.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_fifo_if.slave        bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
`ifdef UART_RX_FIFO_ERR_EN
    localparam int unsigned MW = 9;
`else
    localparam int unsigned MW = 8;
`endif

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t          r_state;
    logic            r_rx_ack;
    logic            r_overflow;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [MW-1:0]   r_mem [DEPTH];

    logic            w_empty;
    logic            w_full;
    logic            w_capture;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [MW-1:0]   w_wdata;
    logic [MW-1:0]   w_head;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_capture = (r_state == S_IDLE) && bus.rx_avail;
    assign w_pop     = bus.rd_en && !w_empty;

`ifdef UART_RX_FIFO_ERR_EN
    assign w_accept  = 1'b1;
    assign w_wdata   = {bus.rx_error, bus.rx_data};
`else
    assign w_accept  = !bus.rx_error;
    assign w_wdata   = bus.rx_data;
`endif

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_push    = w_capture && w_accept && (!w_full || bus.rd_en);
    assign w_drop    = w_capture && w_accept && w_full && !bus.rd_en;

    // Capture handshake, pointers and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rx_ack   <= 1'b0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_avail) begin
                        r_rx_ack <= 1'b1;
                        r_state  <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!bus.rx_avail) begin
                        r_rx_ack <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

            if (w_drop)           r_overflow <= 1'b1;
            else if (bus.clr_ovf) r_overflow <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end

    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.rd_data  = w_head[7:0];
`ifdef UART_RX_FIFO_ERR_EN
    assign bus.rd_err   = w_head[8];
`else
    assign bus.rd_err   = 1'b0;
`endif
    assign bus.rx_ack   = r_rx_ack;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = r_wr_ptr - r_rd_ptr;
    assign bus.overflow = r_overflow;
endmodule
